// File: rtl/scurve_pkg.sv
// Shared widths, state encoding and step helper for the S-curve sweep controller.
// Pure declarations: no latency, no flow control.
package scurve_pkg;

   localparam int DAC_W = 10;
   localparam int CHN_W = 6;
   localparam logic [CHN_W-1:0] CHN_MAX = 6'd63;

   typedef enum logic [2:0] {
      IDLE,
      CFG_REQ,
      CFG_WAIT,
      HEADER,
      RUN,
      RUN_WAIT,
      NEXT,
      DONE
   } state_e;

   // A zero increment would never terminate a sweep, so it runs as a unit step.
   function automatic logic [DAC_W-1:0] eff_step(input logic [DAC_W-1:0] step);
      return (step == '0) ? DAC_W'(1) : step;
   endfunction

endpackage

// File: rtl/scurve_test_control_if.sv
// Sweep controller handshake bundle: launch/abort controls, slow-control loader, channel counter, header FIFO.
// master = sweep controller, slave = its environment (loader, counter block, FIFO, host).
interface scurve_test_control_if;
   import scurve_pkg::*;

   logic                   Test_Start;
   logic                   Test_Stop;
   logic [DAC_W-1:0]       Start_Dac;
   logic [DAC_W-1:0]       End_Dac;
   logic [DAC_W-1:0]       Dac_Step;
   logic                   Single_Channel_Mode;
   logic [CHN_W-1:0]       Single_Channel;
   logic                   Config_Req;
   logic [DAC_W-1:0]       Config_Dac;
   logic [CHN_W-1:0]       Config_Channel;
   logic                   Config_Done;
   logic                   SCurve_Test_Start;
   logic                   One_Channel_Done;
   logic                   Fifo_Full;
   logic [CHN_W+DAC_W-1:0] Ctrl_Data;
   logic                   Ctrl_Data_wr_en;
   logic                   Test_Busy;
   logic                   Test_Done;

   modport master (
      input  Test_Start, Test_Stop, Start_Dac, End_Dac, Dac_Step,
      input  Single_Channel_Mode, Single_Channel,
      input  Config_Done, One_Channel_Done, Fifo_Full,
      output Config_Req, Config_Dac, Config_Channel, SCurve_Test_Start,
      output Ctrl_Data, Ctrl_Data_wr_en, Test_Busy, Test_Done
   );

   modport slave (
      output Test_Start, Test_Stop, Start_Dac, End_Dac, Dac_Step,
      output Single_Channel_Mode, Single_Channel,
      output Config_Done, One_Channel_Done, Fifo_Full,
      input  Config_Req, Config_Dac, Config_Channel, SCurve_Test_Start,
      input  Ctrl_Data, Ctrl_Data_wr_en, Test_Busy, Test_Done
   );

endinterface

// File: rtl/scurve_step_gen.sv
// Latches sweep bounds on load and walks dac (inner) then channel (outer) on each advance; one-cycle update.
// No backpressure: last_step is combinational so the controller can stop before advancing past the end.
module scurve_step_gen
   import scurve_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             advance,
   input  logic [DAC_W-1:0] start_dac,
   input  logic [DAC_W-1:0] end_dac,
   input  logic [DAC_W-1:0] dac_step,
   input  logic             single_mode,
   input  logic [CHN_W-1:0] single_channel,
   output logic [DAC_W-1:0] dac,
   output logic [CHN_W-1:0] channel,
   output logic             last_step
);

   logic [DAC_W-1:0] start_q, start_d, end_q, end_d, step_q, step_d, dac_q, dac_d;
   logic [CHN_W-1:0] chan_q, chan_d;
   logic             single_q, single_d;
   logic [DAC_W:0]   sum;
   logic             dac_wrap;

   // One extra bit keeps End_Dac near full scale from wrapping back into range.
   assign sum       = {1'b0, dac_q} + {1'b0, step_q};
   assign dac_wrap  = sum > {1'b0, end_q};
   assign last_step = dac_wrap && (single_q || chan_q == CHN_MAX);
   assign dac       = dac_q;
   assign channel   = chan_q;

   always_comb begin
      start_d  = start_q;
      end_d    = end_q;
      step_d   = step_q;
      single_d = single_q;
      dac_d    = dac_q;
      chan_d   = chan_q;
      if (load) begin
         start_d  = start_dac;
         end_d    = end_dac;
         step_d   = eff_step(dac_step);
         single_d = single_mode;
         dac_d    = start_dac;
         chan_d   = single_mode ? single_channel : '0;
      end else if (advance) begin
         if (dac_wrap) begin
            dac_d  = start_q;
            chan_d = chan_q + CHN_W'(1);
         end else begin
            dac_d  = sum[DAC_W-1:0];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         start_q  <= '0;
         end_q    <= '0;
         step_q   <= '0;
         single_q <= 1'b0;
         dac_q    <= '0;
         chan_q   <= '0;
      end else begin
         start_q  <= start_d;
         end_q    <= end_d;
         step_q   <= step_d;
         single_q <= single_d;
         dac_q    <= dac_d;
         chan_q   <= chan_d;
      end
   end

endmodule

// File: rtl/scurve_test_control.sv
// S-curve sweep controller: per step loads config, optionally writes a FIFO header, runs one channel test.
// SCURVE_HEADER_EN enables the header write (stalls on Fifo_Full); all outputs registered, one cycle after state.
module scurve_test_control
   import scurve_pkg::*;
(
   input logic                   Clk,
   input logic                   reset,
   scurve_test_control_if.master bus
);

`ifdef SCURVE_HEADER_EN
   localparam state_e AFTER_CFG = HEADER;
`else
   localparam state_e AFTER_CFG = RUN;
`endif

   state_e           state_q, state_d;
   logic             start_prev_q, start_prev_d;
   logic             config_req_q, config_req_d;
   logic             scurve_start_q, scurve_start_d;
   logic             wr_en_q, wr_en_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             launch, load, advance, last_step;
   logic [DAC_W-1:0] dac;
   logic [CHN_W-1:0] channel;

   scurve_step_gen u_step_gen (
      .clk            (Clk),
      .reset          (reset),
      .load           (load),
      .advance        (advance),
      .start_dac      (bus.Start_Dac),
      .end_dac        (bus.End_Dac),
      .dac_step       (bus.Dac_Step),
      .single_mode    (bus.Single_Channel_Mode),
      .single_channel (bus.Single_Channel),
      .dac            (dac),
      .channel        (channel),
      .last_step      (last_step)
   );

   // busy_q stays high through the Test_Done cycle, so an edge landing there is ignored.
   assign launch = bus.Test_Start && !start_prev_q && !busy_q;

   always_comb begin
      state_d        = state_q;
      start_prev_d   = bus.Test_Start;
      config_req_d   = 1'b0;
      scurve_start_d = 1'b0;
      wr_en_d        = 1'b0;
      done_d         = 1'b0;
      load           = 1'b0;
      advance        = 1'b0;
      case (state_q)
         IDLE: begin
            if (launch) begin
               load    = 1'b1;
               state_d = (bus.Start_Dac > bus.End_Dac) ? DONE : CFG_REQ;
            end
         end
         CFG_REQ: begin
            config_req_d = 1'b1;
            state_d      = CFG_WAIT;
         end
         CFG_WAIT: begin
            if (bus.Config_Done) state_d = AFTER_CFG;
            else                 config_req_d = 1'b1;
         end
         HEADER: begin
`ifdef SCURVE_HEADER_EN
            if (!bus.Fifo_Full) begin
               wr_en_d = 1'b1;
               state_d = RUN;
            end
`else
            state_d = RUN;
`endif
         end
         RUN: begin
            scurve_start_d = 1'b1;
            state_d        = RUN_WAIT;
         end
         RUN_WAIT: begin
            if (bus.One_Channel_Done) state_d = NEXT;
            else                      scurve_start_d = 1'b1;
         end
         NEXT: begin
            if (bus.Test_Stop || last_step) begin
               state_d = DONE;
            end else begin
               advance = 1'b1;
               state_d = CFG_REQ;
            end
         end
         DONE: begin
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE) || (state_q == DONE);
   end

   always_ff @(posedge Clk) begin
      if (reset) begin
         state_q        <= IDLE;
         start_prev_q   <= 1'b0;
         config_req_q   <= 1'b0;
         scurve_start_q <= 1'b0;
         wr_en_q        <= 1'b0;
         busy_q         <= 1'b0;
         done_q         <= 1'b0;
      end else begin
         state_q        <= state_d;
         start_prev_q   <= start_prev_d;
         config_req_q   <= config_req_d;
         scurve_start_q <= scurve_start_d;
         wr_en_q        <= wr_en_d;
         busy_q         <= busy_d;
         done_q         <= done_d;
      end
   end

   assign bus.Config_Req        = config_req_q;
   assign bus.Config_Dac        = dac;
   assign bus.Config_Channel    = channel;
   assign bus.SCurve_Test_Start = scurve_start_q;
   assign bus.Ctrl_Data_wr_en   = wr_en_q;
   assign bus.Test_Busy         = busy_q;
   assign bus.Test_Done         = done_q;
`ifdef SCURVE_HEADER_EN
   assign bus.Ctrl_Data         = {channel, dac};
`else
   assign bus.Ctrl_Data         = '0;
`endif

endmodule

// File: tb/tb_scurve_test_control.sv
// Bench for scurve_test_control: responders emulate loader and channel counter; a queue model predicts every step.
module tb_scurve_test_control;
   import scurve_pkg::*;

   logic Clk = 1'b0;
   logic reset;
   scurve_test_control_if ifc();

   scurve_test_control dut (.Clk(Clk), .reset(reset), .bus(ifc));

   always #5 Clk = ~Clk;

   int vectors = 0;
   int miscompares = 0;

   logic [15:0] cfg_q[$];
   logic [15:0] hdr_q[$];
   logic [15:0] exp_q[$];
   logic [15:0] held_cfg;
   int  hs_cnt = 0, done_cnt = 0, viol_cnt = 0, req_fall_cnt = 0;
   int  cyc = 0, req_fall_cyc = 0, start_rise_cyc = 0;
   int  hs_base, done_base, viol_base;
   bit  prev_req = 0, prev_start = 0;
   bit  auto_cfg = 1;
   int  cfg_dly = 0, run_dly = 0;

   // Slow-control loader: one-cycle Config_Done after a random 0..3 cycle delay.
   initial begin
      ifc.Config_Done = 1'b0;
      forever begin
         @(posedge Clk); #1;
         if (ifc.Config_Done) ifc.Config_Done = 1'b0;
         else if (ifc.Config_Req === 1'b1 && auto_cfg) begin
            if (cfg_dly == 0) begin
               ifc.Config_Done = 1'b1;
               cfg_dly = $urandom_range(0, 3);
            end else cfg_dly--;
         end
      end
   end

   initial begin
      ifc.One_Channel_Done = 1'b0;
      forever begin
         @(posedge Clk); #1;
         if (ifc.One_Channel_Done) ifc.One_Channel_Done = 1'b0;
         else if (ifc.SCurve_Test_Start === 1'b1) begin
            if (run_dly == 0) begin
               ifc.One_Channel_Done = 1'b1;
               run_dly = $urandom_range(0, 3);
            end else run_dly--;
         end
      end
   end

   // Observer: logs config requests, header writes, handshakes and protocol violations.
   initial begin
      forever begin
         @(posedge Clk); #2;
         cyc++;
         if (ifc.Config_Req === 1'b1 && !prev_req) begin
            held_cfg = {ifc.Config_Channel, ifc.Config_Dac};
            cfg_q.push_back(held_cfg);
         end else if (ifc.Config_Req === 1'b1 && {ifc.Config_Channel, ifc.Config_Dac} !== held_cfg)
            viol_cnt++;
         if (ifc.Config_Req !== 1'b1 && prev_req) begin
            req_fall_cnt++;
            req_fall_cyc = cyc;
         end
         if (ifc.SCurve_Test_Start === 1'b1 && !prev_start) start_rise_cyc = cyc;
         if (ifc.Ctrl_Data_wr_en === 1'b1) begin
            hdr_q.push_back(ifc.Ctrl_Data);
            if (ifc.SCurve_Test_Start === 1'b1) viol_cnt++;
         end
         if (ifc.Config_Req === 1'b1 && ifc.SCurve_Test_Start === 1'b1) viol_cnt++;
         if (ifc.SCurve_Test_Start === 1'b1 && ifc.One_Channel_Done) hs_cnt++;
         if (ifc.Test_Done === 1'b1) done_cnt++;
         prev_req   = (ifc.Config_Req === 1'b1);
         prev_start = (ifc.SCurve_Test_Start === 1'b1);
      end
   end

   function automatic logic [36:0] outs();
      return {ifc.Config_Req, ifc.Config_Dac, ifc.Config_Channel, ifc.SCurve_Test_Start,
              ifc.Ctrl_Data, ifc.Ctrl_Data_wr_en, ifc.Test_Busy, ifc.Test_Done};
   endfunction

   // Every (channel, dac) pair the sweep must visit, in order.
   function automatic void build_model(input int s, input int e, input int st, input bit single, input int ch);
      int step;
      exp_q.delete();
      if (s > e) return;
      step = (st == 0) ? 1 : st;
      for (int c = 0; c < 64; c++) begin
         if (single && c != ch) continue;
         for (int d = s; d <= e; d += step) exp_q.push_back({c[5:0], d[9:0]});
      end
   endfunction

   task automatic launch(input int s, input int e, input int st, input bit single, input int ch);
      @(negedge Clk);
      ifc.Start_Dac = s[9:0];
      ifc.End_Dac = e[9:0];
      ifc.Dac_Step = st[9:0];
      ifc.Single_Channel_Mode = single;
      ifc.Single_Channel = ch[5:0];
      cfg_q.delete();
      hdr_q.delete();
      hs_base = hs_cnt; done_base = done_cnt; viol_base = viol_cnt;
      build_model(s, e, st, single, ch);
      ifc.Test_Start = 1'b1;
      @(negedge Clk);
      // Parameters must have been captured at launch; disturb them now.
      ifc.Start_Dac = 10'($urandom);
      ifc.End_Dac = 10'($urandom);
      ifc.Dac_Step = 10'($urandom);
      ifc.Single_Channel_Mode = 1'($urandom);
      ifc.Single_Channel = 6'($urandom);
      @(negedge Clk);
      ifc.Test_Start = 1'b0;
   endtask

   task automatic wait_done(input string name, input int limit);
      int n = 0;
      while (done_cnt == done_base && n < limit) begin
         @(negedge Clk);
         n++;
      end
      vectors++;
      if (done_cnt == done_base) begin
         miscompares++;
         $display("FAIL %s done_timeout: got 0 Test_Done pulses in %0d cycles, expected 1", name, limit);
      end
   endtask

   task automatic check_logs(input string name);
      int bad = -1;
      @(negedge Clk);
      vectors++;
      if (ifc.Test_Busy !== 1'b0) begin
         miscompares++;
         $display("FAIL %s busy_after_done: got %b, expected 0", name, ifc.Test_Busy);
      end
      vectors++;
      if (cfg_q.size() != exp_q.size()) begin
         miscompares++;
         $display("FAIL %s step_count: got %0d config requests, expected %0d", name, cfg_q.size(), exp_q.size());
      end else begin
         foreach (exp_q[i]) if (bad < 0 && cfg_q[i] !== exp_q[i]) bad = i;
         vectors++;
         if (bad >= 0) begin
            miscompares++;
            $display("FAIL %s step_values: step %0d got %h, expected %h", name, bad, cfg_q[bad], exp_q[bad]);
         end
      end
      vectors++;
      if (hs_cnt - hs_base != exp_q.size()) begin
         miscompares++;
         $display("FAIL %s handshakes: got %0d, expected %0d", name, hs_cnt - hs_base, exp_q.size());
      end
      vectors++;
      if (done_cnt - done_base != 1) begin
         miscompares++;
         $display("FAIL %s done_pulses: got %0d, expected 1", name, done_cnt - done_base);
      end
      vectors++;
      if (viol_cnt != viol_base) begin
         miscompares++;
         $display("FAIL %s protocol: got %0d overlap/instability events, expected 0", name, viol_cnt - viol_base);
      end
      vectors++;
`ifdef SCURVE_HEADER_EN
      if (hdr_q != exp_q) begin
         miscompares++;
         $display("FAIL %s headers: got %0d words (first %h), expected %0d (first %h)", name,
                  hdr_q.size(), (hdr_q.size() > 0) ? hdr_q[0] : 16'h0, exp_q.size(), (exp_q.size() > 0) ? exp_q[0] : 16'h0);
      end
`else
      if (hdr_q.size() != 0) begin
         miscompares++;
         $display("FAIL %s headers: got %0d write strobes, expected 0", name, hdr_q.size());
      end
`endif
   endtask

   task automatic test_reset();
      reset = 1'b1;
      ifc.Test_Start = 0; ifc.Test_Stop = 0; ifc.Fifo_Full = 0;
      ifc.Start_Dac = 0; ifc.End_Dac = 0; ifc.Dac_Step = 0;
      ifc.Single_Channel_Mode = 0; ifc.Single_Channel = 0;
      repeat (3) @(negedge Clk);
      vectors++;
      if (outs() !== 37'h0) begin
         miscompares++;
         $display("FAIL reset_outputs: got %h, expected 0", outs());
      end
      reset = 1'b0;
      repeat (2) @(negedge Clk);
   endtask

   task automatic test_single_channel();
      launch(100, 110, 5, 1'b1, 5);
      wait_done("single", 2000);
      check_logs("single");
      vectors++;
      if (cfg_q.size() != 3 || cfg_q[0] !== 16'h1464 || cfg_q[1] !== 16'h1469 || cfg_q[2] !== 16'h146E) begin
         miscompares++;
         $display("FAIL single_literal: got %0d steps, expected 1464 1469 146e", cfg_q.size());
      end
   endtask

   task automatic test_empty_range();
      @(negedge Clk);
      ifc.Start_Dac = 10'd200; ifc.End_Dac = 10'd100; ifc.Dac_Step = 10'd1;
      cfg_q.delete();
      done_base = done_cnt;
      ifc.Test_Start = 1'b1;
      @(negedge Clk);
      vectors++;
      if ({ifc.Test_Busy, ifc.Test_Done} !== 2'b10) begin
         miscompares++;
         $display("FAIL empty_cycle1: got busy,done=%b, expected 10", {ifc.Test_Busy, ifc.Test_Done});
      end
      @(negedge Clk);
      vectors++;
      if ({ifc.Test_Busy, ifc.Test_Done} !== 2'b11) begin
         miscompares++;
         $display("FAIL empty_cycle2: got busy,done=%b, expected 11", {ifc.Test_Busy, ifc.Test_Done});
      end
      @(negedge Clk);
      vectors++;
      if ({ifc.Test_Busy, ifc.Test_Done} !== 2'b00) begin
         miscompares++;
         $display("FAIL empty_cycle3: got busy,done=%b, expected 00", {ifc.Test_Busy, ifc.Test_Done});
      end
      // Test_Start still high: a level is not a fresh launch.
      repeat (5) @(negedge Clk);
      vectors++;
      if (cfg_q.size() != 0 || done_cnt - done_base != 1 || ifc.Test_Busy !== 1'b0) begin
         miscompares++;
         $display("FAIL empty_quiet: got %0d configs %0d dones busy=%b, expected 0 1 0",
                  cfg_q.size(), done_cnt - done_base, ifc.Test_Busy);
      end
      ifc.Test_Start = 1'b0;
   endtask

   task automatic test_fifo_full();
      int n0, n, exp_gap;
`ifdef SCURVE_HEADER_EN
      exp_gap = 12;
`else
      exp_gap = 1;
`endif
      ifc.Fifo_Full = 1'b1;
      n0 = req_fall_cnt;
      launch(50, 50, 0, 1'b1, 9);
      n = 0;
      while (req_fall_cnt == n0 && n < 200) begin
         @(negedge Clk);
         n++;
      end
      repeat (10) @(negedge Clk);
      ifc.Fifo_Full = 1'b0;
      wait_done("fifo_full", 500);
      check_logs("fifo_full");
      vectors++;
      if (start_rise_cyc - req_fall_cyc != exp_gap) begin
         miscompares++;
         $display("FAIL fifo_full_delay: got %0d cycles Config_Req fall to run start, expected %0d",
                  start_rise_cyc - req_fall_cyc, exp_gap);
      end
   endtask

   task automatic test_stop();
      int n = 0;
      launch(300, 300, 0, 1'b0, 0);
      while (!(ifc.SCurve_Test_Start === 1'b1 && ifc.Config_Channel == 6'd3) && n < 2000) begin
         @(negedge Clk);
         n++;
      end
      vectors++;
      if (n >= 2000) begin
         miscompares++;
         $display("FAIL stop_reach_ch3: got timeout, expected channel 3 run");
      end
      ifc.Test_Stop = 1'b1;
      wait_done("stop", 2000);
      ifc.Test_Stop = 1'b0;
      while (exp_q.size() > 4) void'(exp_q.pop_back());
      check_logs("stop");
      repeat (10) @(negedge Clk);
      vectors++;
      if (cfg_q.size() != 4) begin
         miscompares++;
         $display("FAIL stop_no_more_cfg: got %0d config requests, expected 4", cfg_q.size());
      end
   endtask

   task automatic test_back_to_back();
      launch(10, 40, 10, 1'b1, 60);
      repeat (3) @(negedge Clk);
      ifc.Test_Start = 1'b1;
      repeat (2) @(negedge Clk);
      ifc.Test_Start = 1'b0;
      repeat (2) @(negedge Clk);
      ifc.Test_Start = 1'b1;
      wait_done("b2b_first", 2000);
      check_logs("b2b_first");
      repeat (5) @(negedge Clk);
      vectors++;
      if (ifc.Test_Busy !== 1'b0 || cfg_q.size() != 4) begin
         miscompares++;
         $display("FAIL b2b_no_relaunch: got busy=%b configs=%0d, expected 0 4", ifc.Test_Busy, cfg_q.size());
      end
      ifc.Test_Start = 1'b0;
      launch(1000, 1023, 7, 1'b1, 0);
      wait_done("b2b_second", 2000);
      check_logs("b2b_second");
   endtask

   task automatic test_reset_mid();
      int n = 0;
      auto_cfg = 0;
      launch(5, 9, 1, 1'b1, 2);
      while (ifc.Config_Req !== 1'b1 && n < 50) begin
         @(negedge Clk);
         n++;
      end
      repeat (2) @(negedge Clk);
      reset = 1'b1;
      @(negedge Clk);
      vectors++;
      if (outs() !== 37'h0) begin
         miscompares++;
         $display("FAIL reset_mid_outputs: got %h, expected 0", outs());
      end
      reset = 1'b0;
      auto_cfg = 1;
      repeat (20) @(negedge Clk);
      vectors++;
      if (done_cnt != done_base || ifc.Test_Busy !== 1'b0 || ifc.Config_Req !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_mid_idle: got dones=%0d busy=%b req=%b, expected 0 0 0",
                  done_cnt - done_base, ifc.Test_Busy, ifc.Config_Req);
      end
   endtask

   task automatic test_random();
      int s, e, st, ch;
      bit single;
      for (int it = 0; it < 6; it++) begin
         single = 1'($urandom_range(0, 1));
         ch = $urandom_range(0, 63);
         s = $urandom_range(0, 1023);
         if (single) begin
            e = s + $urandom_range(0, 150);
            st = $urandom_range(0, 15);
         end else begin
            e = s + $urandom_range(0, 5);
            st = $urandom_range(2, 6);
         end
         if (e > 1023) e = 1023;
         if ($urandom_range(0, 4) == 0) begin
            s = $urandom_range(1, 1023);
            e = $urandom_range(0, s - 1);
         end
         launch(s, e, st, single, ch);
         wait_done($sformatf("random%0d", it), 30000);
         check_logs($sformatf("random%0d", it));
      end
   endtask

   task automatic test_full_range();
      launch(1020, 1023, 0, 1'b0, 0);
      wait_done("full_range", 20000);
      check_logs("full_range");
      vectors++;
      if (hs_cnt - hs_base != 256 || cfg_q.size() != 256) begin
         miscompares++;
         $display("FAIL full_range_256: got %0d handshakes %0d configs, expected 256 256",
                  hs_cnt - hs_base, cfg_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_single_channel();
      test_empty_range();
      test_fifo_full();
      test_stop();
      test_back_to_back();
      test_reset_mid();
      test_random();
      test_full_range();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/scurve_test_control.md
SCURVE_TEST_CONTROL -- requirements
Module: scurve_test_control

Interface
REQ-001 Clk  in  1  system clock; all logic on rising edge.
REQ-002 reset  in  1  synchronous, active-high reset.
REQ-003 Test_Start  in  1  level; rising edge launches a sweep.
REQ-004 Test_Stop  in  1  level; graceful abort request.
REQ-005 Start_Dac / End_Dac / Dac_Step  in  10 each  threshold sweep bounds and increment; sampled at launch.
REQ-006 Single_Channel_Mode  in  1  1 = sweep only Single_Channel; 0 = channels 0..63. Sampled at launch.
REQ-007 Single_Channel  in  6  channel used when Single_Channel_Mode=1.
REQ-008 Config_Req  out  1  slow-control load request; held until Config_Done.
REQ-009 Config_Dac  out  10  threshold for the current step; stable while Config_Req=1.
REQ-010 Config_Channel  out  6  channel to unmask for the current step; stable while Config_Req=1.
REQ-011 Config_Done  in  1  one-cycle completion pulse from the slow-control loader.
REQ-012 SCurve_Test_Start  out  1  level to the single-channel counter block; held until One_Channel_Done.
REQ-013 One_Channel_Done  in  1  completion from the single-channel counter block.
REQ-014 Fifo_Full  in  1  shared data FIFO full flag.
REQ-015 Ctrl_Data  out  16  header word {Config_Channel[5:0], Config_Dac[9:0]}.
REQ-016 Ctrl_Data_wr_en  out  1  one-cycle FIFO write strobe for Ctrl_Data.
REQ-017 Test_Busy  out  1  high from launch until return to IDLE.
REQ-018 Test_Done  out  1  one-cycle pulse on sweep end (normal or aborted).

Function
REQ-019 States: IDLE, CFG_REQ, CFG_WAIT, HEADER, RUN, RUN_WAIT, NEXT, DONE.
REQ-020 IDLE: on Test_Start 0->1 (registered edge), latch parameters, channel = Single_Channel_Mode ? Single_Channel : 0, dac = Start_Dac; go CFG_REQ; if Start_Dac > End_Dac go DONE directly.
REQ-021 CFG_REQ: assert Config_Req; go CFG_WAIT. CFG_WAIT: hold Config_Req until Config_Done, then deassert and go HEADER.
REQ-022 HEADER: if Fifo_Full=0, pulse Ctrl_Data_wr_en for exactly one cycle and go RUN; else stall.
REQ-023 RUN: assert SCurve_Test_Start; go RUN_WAIT. RUN_WAIT: on One_Channel_Done, deassert SCurve_Test_Start, go NEXT.
REQ-024 NEXT: effective step = (Dac_Step==0) ? 1 : Dac_Step; 11-bit sum dac+step; if sum <= End_Dac, dac = sum; else dac = Start_Dac and advance channel.
REQ-025 Channel advance: single-channel mode or channel==63 -> DONE; else channel+1. Next step goes to CFG_REQ.
REQ-026 Test_Stop sampled in NEXT only: if high, go DONE; an in-flight config or channel test always completes.
REQ-027 DONE: pulse Test_Done one cycle; Test_Busy low next cycle; go IDLE.
REQ-028 Test_Start edges while Test_Busy=1 ignored; relaunch requires a fresh rising edge.
REQ-029 SCurve_Test_Start and Config_Req never high simultaneously; Ctrl_Data_wr_en never high while SCurve_Test_Start=1.
REQ-030 Steps per channel = floor((End_Dac-Start_Dac)/step)+1; End_Dac=1023 must not wrap.

Reset
REQ-031 reset=1: state IDLE; all outputs 0; latched parameters, channel, dac and edge register 0.
REQ-032 reset mid-sweep abandons the sweep without Test_Done; downstream blocks must be reset separately.

Configuration
REQ-033 Macro SCURVE_HEADER_EN: defined -> HEADER state as REQ-022; undefined -> HEADER skipped (CFG_WAIT goes to RUN), Ctrl_Data_wr_en tied 0, Ctrl_Data tied 0, Fifo_Full unused.

Structure
REQ-034 Shared package scurve_pkg: state encoding, DAC_W=10, CHN_W=6, CHN_MAX=63.
REQ-035 One sub-module natural: scurve_step_gen (dac/channel counters, REQ-024/025 arithmetic); FSM stays in top.

Verification
REQ-036 Single_Channel_Mode=1, channel 5, Start=100, End=110, Step=5 -> 3 steps, headers 0x1464, 0x1469, 0x146E, then Test_Done.
REQ-037 Start=200, End=100 -> no Config_Req, Test_Done 2 cycles after edge.
REQ-038 Start=1020, End=1023, Step=0 -> dac 1020..1023 per channel, 64 channels, 256 One_Channel_Done handshakes, no wrap.
REQ-039 Fifo_Full held 10 cycles in HEADER -> SCurve_Test_Start delayed 10 cycles, exactly one write strobe.
REQ-040 Test_Stop asserted during RUN_WAIT of channel 3 -> that step completes, Test_Done, no further Config_Req.
REQ-041 reset asserted in CFG_WAIT -> next cycle all outputs 0, state IDLE, no Test_Done.
